// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus view of the UART transmitter. These are the same strobes, address and data
// that the data RAM decode sees, so the UART can sit in parallel with the RAM.
interface mmio_uart_tx_if;
    logic        cs;
    logic        dm_w;
    logic        dm_r;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (output cs, dm_w, dm_r, addr, data_in, input data_out);
    modport slave  (input cs, dm_w, dm_r, addr, data_in, output data_out);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter with a 16-byte register window, a TX FIFO and an 8N1 serialiser.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR = 32'h10020000,
    parameter int          CLK_DIV   = 868,
    parameter int          FIFO_AW   = 4
) (
    input  logic          clk_in,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          tx,
    output logic          irq
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
`ifdef UART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       sh, sh_next;
    logic             tx_q, tx_next;
    logic [FIFO_AW:0] wr_ptr, rd_ptr, count;
    logic [7:0]       mem [DEPTH];
    logic [7:0]       pop_byte;
    logic [3:0]       offset;
    logic             hit, wr_en, push, pop, clr_ovf, tick;
    logic             ovf, full, empty;
    logic             unused_data;
`ifdef UART_PARITY_EN
    logic             par_q;
`endif

    assign offset      = bus.addr[3:0];
    assign hit         = bus.cs && (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign wr_en       = hit && bus.dm_w;
    assign push        = wr_en && (offset == 4'h0);
    assign clr_ovf     = wr_en && (offset == 4'h4);
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                         (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign count       = wr_ptr - rd_ptr;
    assign pop_byte    = mem[rd_ptr[FIFO_AW-1:0]];
    assign irq         = empty && (state == IDLE);
    assign tx          = tx_q;
    assign unused_data = ^bus.data_in[31:8];

    always_comb begin
        bus.data_out = '0;
        if (hit && bus.dm_r && !bus.dm_w) begin
            case (offset)
                4'h4:    bus.data_out = {27'd0, PAR_EN, ovf, state != IDLE, empty, full};
                4'h8:    bus.data_out = 32'(count);
                default: bus.data_out = '0;
            endcase
        end
    end

    // A push into a full FIFO is dropped even if the serialiser pops in the same cycle.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                if (full) ovf <= 1'b1;
                else      wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
            end
            if (clr_ovf) ovf <= 1'b0;
            if (pop) rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push && !full) mem[wr_ptr[FIFO_AW-1:0]] <= bus.data_in[7:0];
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        sh_next    = sh;
        pop        = 1'b0;
        tick       = (cnt == CNT_MAX);
        tx_next    = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    sh_next    = pop_byte;
                    state_next = START;
                end
            end
            START: if (tick) state_next = DATA;
            DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        sh_next  = {1'b0, sh[7:1]};
                        bit_next = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: if (tick) state_next = STOP;
`endif
            STOP: if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if ((state_next != state) || (state == IDLE) || tick) cnt_next = '0;
        else                                                   cnt_next = cnt + CW'(1);
        if (state_next != state) bit_next = 3'd0;

        // tx is registered, so it is driven from the state being entered.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = sh_next[0];
`ifdef UART_PARITY_EN
            PARITY:  tx_next = par_q;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            sh      <= 8'd0;
            tx_q    <= 1'b1;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            sh      <= sh_next;
            tx_q    <= tx_next;
`ifdef UART_PARITY_EN
            if (pop) par_q <= ^pop_byte;
`endif
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised scoreboard bench for mmio_uart_tx: writes push expected bytes into a queue and a
// line monitor decodes frames on tx and pops/compares them independently.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE    = 32'h10020000;
    localparam int          CLK_DIV = 4;
    localparam int          FIFO_AW = 2;
    localparam int          DEPTH   = 1 << FIFO_AW;
`ifdef UART_PARITY_EN
    localparam int          NBITS   = 11;
    localparam logic [31:0] PAR_BIT = 32'h10;
`else
    localparam int          NBITS   = 10;
    localparam logic [31:0] PAR_BIT = 32'h0;
`endif
    localparam int FRAME = NBITS * CLK_DIV;
    localparam int DRAIN_LIMIT = (DEPTH + 2) * (FRAME + 1) + 20;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;
    logic tx, irq;
    int   checks = 0, failures = 0, cycle = 0;

    logic [7:0] exp_q[$];
    int         frame_starts[$];
    int         m_count = 0;
    bit         m_busy = 1'b0, m_ovf = 1'b0;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clk_in(clk_in),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .irq   (irq)
    );

    initial forever #5 clk_in = ~clk_in;
    initial forever begin
        @(posedge clk_in);
        cycle++;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Line-level view of a frame, LSB first: start, data, optional even parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_PARITY_EN
        f[9]  = ^b;
        f[10] = 1'b1;
`else
        f[9]  = 1'b1;
`endif
        return f;
    endfunction

    // One clock edge of the abstract model: the idle transmitter takes the head byte,
    // and a push into a FIFO that was full before this edge is lost.
    function automatic void model_edge(input bit do_push, input logic [7:0] b);
        bit was_full;
        was_full = (m_count == DEPTH);
        if (!m_busy && m_count > 0) begin
            m_count--;
            m_busy = 1'b1;
        end
        if (do_push) begin
            if (was_full) m_ovf = 1'b1;
            else begin
                m_count++;
                exp_q.push_back(b);
            end
        end
    endfunction

    function automatic logic [31:0] expected_status();
        return PAR_BIT | {28'd0, m_ovf, m_busy, m_count == 0, m_count == DEPTH};
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_in);
        bus.cs = 1'b1; bus.dm_w = 1'b1; bus.dm_r = 1'b0; bus.addr = a; bus.data_in = d;
        @(posedge clk_in);
        #1;
        bus.cs = 1'b0; bus.dm_w = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk_in);
        bus.cs = 1'b1; bus.dm_r = 1'b1; bus.dm_w = 1'b0; bus.addr = a;
        #1 d = bus.data_out;
        bus.cs = 1'b0; bus.dm_r = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [7:0] b);
        logic [31:0] d;
        d = $urandom;
        d[7:0] = b;
        bus_write(BASE, d);
        model_edge(1'b1, b);
    endtask

    task automatic idle_cycle();
        @(posedge clk_in);
        #1;
        model_edge(1'b0, 8'h00);
    endtask

    task automatic check_status(input string name);
        logic [31:0] s, c;
        @(negedge clk_in);
        bus.cs = 1'b1; bus.dm_r = 1'b1; bus.dm_w = 1'b0; bus.addr = BASE + 32'h4;
        #1 s = bus.data_out;
        bus.addr = BASE + 32'h8;
        #1 c = bus.data_out;
        bus.cs = 1'b0; bus.dm_r = 1'b0;
        check_output({name, " status"}, s, expected_status());
        check_output({name, " count"}, c, 32'(m_count));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || irq !== 1'b1) && n < DRAIN_LIMIT) begin
            @(negedge clk_in);
            n++;
        end
        check_output({name, " drained"}, {31'd0, exp_q.size() == 0 && irq === 1'b1}, 32'd1);
        m_count = 0;
        m_busy  = 1'b0;
    endtask

    // Monitor: finds each falling edge on an idle line and samples mid-bit.
    initial begin : monitor
        logic        prev;
        logic [10:0] bits;
        bit          aborted;
        int          start;
        prev = 1'b1;
        forever begin
            @(negedge clk_in);
            if (!reset) prev = 1'b1;
            else if (prev && !tx) begin
                start   = cycle;
                bits    = '0;
                aborted = 1'b0;
                for (int t = 1; t <= (NBITS - 1) * CLK_DIV + CLK_DIV / 2; t++) begin
                    @(negedge clk_in);
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (t % CLK_DIV == CLK_DIV / 2) bits[t / CLK_DIV] = tx;
                end
                if (!aborted) begin
                    frame_starts.push_back(start);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected frame: got %h expected no frame", bits);
                    end else begin
                        check_output("frame", 32'(bits), 32'(frame_bits(exp_q.pop_front())));
                    end
                end
                prev = aborted ? 1'b1 : tx;
            end else prev = tx;
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic [31:0] d;
        int n;
        bus.cs = 1'b0; bus.dm_w = 1'b0; bus.dm_r = 1'b0; bus.addr = '0; bus.data_in = '0;

        // Reset state
        repeat (3) @(negedge clk_in);
        check_output("reset tx", {31'd0, tx}, 32'd1);
        check_output("reset irq", {31'd0, irq}, 32'd1);
        reset = 1'b1;
        check_status("after reset");

        // Single frame 0xA5: fall one cycle after the write edge, irq back after the stop bit
        bus_write(BASE, 32'hFFFFFFA5);
        model_edge(1'b1, 8'hA5);
        @(negedge clk_in);
        check_output("tx before fall", {31'd0, tx}, 32'd1);
        check_output("irq after write", {31'd0, irq}, 32'd0);
        @(negedge clk_in);
        check_output("tx start bit", {31'd0, tx}, 32'd0);
        repeat (FRAME - 1) @(negedge clk_in);
        check_output("irq in stop bit", {31'd0, irq}, 32'd0);
        @(negedge clk_in);
        check_output("irq after frame", {31'd0, irq}, 32'd1);
        drain("single");

        // Burst of six from idle: one popped, four fill the FIFO, the sixth overflows
        frame_starts.delete();
        for (int i = 0; i < 6; i++) apply_stimulus(8'h11 + 8'(i));
        check_status("burst");

        // Clearing ovf, unmapped/out-of-window accesses, simultaneous strobes
        bus_write(BASE + 32'h4, $urandom);
        m_ovf = 1'b0;
        model_edge(1'b0, 8'h00);
        check_status("ovf clear");
        bus_read(BASE + 32'hC, d);
        check_output("read unmapped", d, 32'd0);
        bus_read(32'h10010004, d);
        check_output("read outside window", d, 32'd0);
        bus_read(BASE, d);
        check_output("read txdata", d, 32'd0);
        bus_write(BASE + 32'hC, 32'h99);
        model_edge(1'b0, 8'h00);
        bus_write(32'h10010000, 32'h98);
        model_edge(1'b0, 8'h00);
        check_status("stray writes");
        @(negedge clk_in);
        bus.cs = 1'b1; bus.dm_r = 1'b1; bus.dm_w = 1'b1; bus.addr = BASE + 32'h8;
        #1 d = bus.data_out;
        check_output("read with write strobe", d, 32'd0);
        @(posedge clk_in);
        #1;
        bus.cs = 1'b0; bus.dm_r = 1'b0; bus.dm_w = 1'b0;
        model_edge(1'b0, 8'h00);
        drain("burst");
        check_output("burst frame count", 32'(frame_starts.size()), 32'd5);
        for (int i = 1; i < frame_starts.size(); i++)
            check_output("frame spacing", 32'(frame_starts[i] - frame_starts[i-1]), 32'(FRAME + 1));

        // Even-parity reference byte
        apply_stimulus(8'h07);
        drain("byte 07");

        // Randomised bursts from idle, short enough that only the first byte is popped
        for (int k = 0; k < 12; k++) begin
            int len;
            len = $urandom_range(1, DEPTH + 2);
            for (int j = 0; j < len; j++) begin
                if (j != 0) repeat ($urandom_range(0, 2)) idle_cycle();
                apply_stimulus(8'($urandom));
            end
            check_status("random burst");
            drain("random");
            check_status("random idle");
            if (m_ovf) begin
                bus_write(BASE + 32'h4, 32'h0);
                m_ovf = 1'b0;
            end
        end

        // Reset in the middle of a frame discards everything
        frame_starts.delete();
        apply_stimulus(8'($urandom));
        apply_stimulus(8'($urandom));
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        check_output("mid-reset frame began", {31'd0, tx}, 32'd0);
        repeat (17) @(posedge clk_in);
        #1 reset = 1'b0;
        #1;
        check_output("tx during reset", {31'd0, tx}, 32'd1);
        check_output("irq during reset", {31'd0, irq}, 32'd1);
        exp_q.delete();
        m_count = 0; m_busy = 1'b0; m_ovf = 1'b0;
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
        check_status("after mid reset");
        repeat (3 * FRAME) @(negedge clk_in);
        check_output("frames after reset", 32'(frame_starts.size()), 32'd0);
        check_output("tx idle after reset", {31'd0, tx}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
